// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: Initial/Run/Lose FSM, move-tick timer, direction latch
// and the one-step-per-tick req/done handshake toward the body/food datapath.
module snake_game_ctrl #(
    parameter int MOVE_DIV      = 10_000_000,
    parameter int SCORE_W       = 8,
    parameter bit ALLOW_REVERSE = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               BtnL_p,
    input  logic               BtnR_p,
    input  logic               BtnU_p,
    input  logic               BtnD_p,
    input  logic               step_done,
    input  logic               collide,
    input  logic               food_eaten,
    output logic               step_req,
    output logic [1:0]         step_dir,
    output logic               init_clr,
    output logic [SCORE_W-1:0] score,
    output logic               q_Ini,
    output logic               q_Run,
    output logic               q_Lose
);

    localparam int                 TMR_W     = $clog2(MOVE_DIV);
    localparam logic [TMR_W-1:0]   TICK_AT   = TMR_W'(MOVE_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_L = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    typedef enum logic [1:0] {
        INI      = 2'd0,
        RUN_WAIT = 2'd1,
        STEP     = 2'd2,
        LOSE     = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [TMR_W-1:0]   timer, timer_nx;
    logic [1:0]         dir, dir_nx;
    logic               pend, pend_nx;
    logic [1:0]         pend_dir, pend_dir_nx;
    logic [SCORE_W-1:0] score_nx;

    logic       btn_any;
    logic [1:0] btn_dir;
    logic       btn_ok;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= INI;
            timer    <= '0;
            dir      <= DIR_R;
            pend     <= 1'b0;
            pend_dir <= DIR_R;
            score    <= '0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            dir      <= dir_nx;
            pend     <= pend_nx;
            pend_dir <= pend_dir_nx;
            score    <= score_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        dir_nx      = dir;
        pend_nx     = pend;
        pend_dir_nx = pend_dir;
        score_nx    = score;

        btn_any = BtnU_p | BtnD_p | BtnL_p | BtnR_p;
        btn_dir = BtnU_p ? DIR_U : BtnD_p ? DIR_D : BtnL_p ? DIR_L : DIR_R;
        // Opposite directions differ only in bit 0 (R/L, U/D).
        btn_ok  = btn_any && (ALLOW_REVERSE || (btn_dir != (dir ^ 2'b01)));

        if (btn_ok && (state == RUN_WAIT || state == STEP)) begin
            pend_nx     = 1'b1;
            pend_dir_nx = btn_dir;
        end

        case (state)
            INI: begin
                state_nx = RUN_WAIT;
                timer_nx = '0;
                dir_nx   = DIR_R;
                pend_nx  = 1'b0;
                score_nx = '0;
            end
            RUN_WAIT: begin
                if (timer == TICK_AT) begin
                    timer_nx = '0;
                    state_nx = STEP;
                    // A pulse landing on the tick cycle itself still makes this step.
                    if (pend_nx) dir_nx = pend_dir_nx;
                    pend_nx  = 1'b0;
                end else begin
                    timer_nx = timer + TMR_W'(1);
                end
            end
            STEP: begin
                if (step_done) begin
                    if (collide) begin
                        state_nx = LOSE;
                    end else begin
                        if (food_eaten && score != SCORE_MAX) score_nx = score + SCORE_W'(1);
                        state_nx = RUN_WAIT;
                    end
                end
            end
            LOSE:    state_nx = LOSE;
            default: state_nx = INI;
        endcase
    end

    // Outputs are flops loaded from the next-state decode so they track the state edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_Ini    <= 1'b1;
            q_Run    <= 1'b0;
            q_Lose   <= 1'b0;
            init_clr <= 1'b1;
            step_req <= 1'b0;
            step_dir <= DIR_R;
        end else begin
            q_Ini    <= (state_nx == INI);
            q_Run    <= (state_nx == RUN_WAIT) || (state_nx == STEP);
            q_Lose   <= (state_nx == LOSE);
            init_clr <= (state_nx == INI);
            step_req <= (state_nx == STEP);
            step_dir <= dir_nx;
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: three instances (default, no-reverse, 2-bit score)
// share stimulus; a monitor checks every step_req rise against a scoreboard.
module tb_snake_game_ctrl;

    localparam int MD = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic BtnL_p = 1'b0, BtnR_p = 1'b0, BtnU_p = 1'b0, BtnD_p = 1'b0;
    logic step_done = 1'b0, collide = 1'b0, food_eaten = 1'b0;

    logic       step_req, init_clr, q_Ini, q_Run, q_Lose;
    logic [1:0] step_dir;
    logic [7:0] score;
    logic       req_nr, clr_nr, ini_nr, run_nr, lose_nr;
    logic [1:0] dir_nr;
    logic [7:0] score_nr;
    logic       req_s2, clr_s2, ini_s2, run_s2, lose_s2;
    logic [1:0] dir_s2;
    logic [1:0] score_s2;

    snake_game_ctrl #(.MOVE_DIV(MD), .SCORE_W(8), .ALLOW_REVERSE(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .BtnL_p(BtnL_p), .BtnR_p(BtnR_p), .BtnU_p(BtnU_p), .BtnD_p(BtnD_p),
        .step_done(step_done), .collide(collide), .food_eaten(food_eaten),
        .step_req(step_req), .step_dir(step_dir), .init_clr(init_clr), .score(score),
        .q_Ini(q_Ini), .q_Run(q_Run), .q_Lose(q_Lose));

    snake_game_ctrl #(.MOVE_DIV(MD), .SCORE_W(8), .ALLOW_REVERSE(1'b0)) dut_nr (
        .Clk(Clk), .Reset(Reset), .BtnL_p(BtnL_p), .BtnR_p(BtnR_p), .BtnU_p(BtnU_p), .BtnD_p(BtnD_p),
        .step_done(step_done), .collide(collide), .food_eaten(food_eaten),
        .step_req(req_nr), .step_dir(dir_nr), .init_clr(clr_nr), .score(score_nr),
        .q_Ini(ini_nr), .q_Run(run_nr), .q_Lose(lose_nr));

    snake_game_ctrl #(.MOVE_DIV(MD), .SCORE_W(2), .ALLOW_REVERSE(1'b1)) dut_s2 (
        .Clk(Clk), .Reset(Reset), .BtnL_p(BtnL_p), .BtnR_p(BtnR_p), .BtnU_p(BtnU_p), .BtnD_p(BtnD_p),
        .step_done(step_done), .collide(collide), .food_eaten(food_eaten),
        .step_req(req_s2), .step_dir(dir_s2), .init_clr(clr_s2), .score(score_s2),
        .q_Ini(ini_s2), .q_Run(run_s2), .q_Lose(lose_s2));

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] nr;
        logic [1:0] s2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] nr, input logic [1:0] s2);
        exp_t e;
        e.a = a; e.nr = nr; e.s2 = s2;
        sb.push_back(e);
    endtask

    // Monitor: each step_req rise pops one expected step and checks tick spacing.
    int   gap = 0;
    logic prev_req = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        if (Reset || q_Ini) begin
            gap = 0;
        end else if (step_req && !prev_req) begin
            if (sb.size() == 0) begin
                chk("unexpected_step_req", 32'(step_req), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("step_dir", 32'(step_dir), 32'(e.a));
                chk("step_dir_nr", 32'(dir_nr), 32'(e.nr));
                chk("step_dir_s2", 32'(dir_s2), 32'(e.s2));
                chk("tick_gap", 32'(gap), 32'(MD));
                chk("req_lockstep", 32'({req_nr, req_s2}), 32'd3);
            end
            gap = 0;
        end else if (q_Run && !step_req) begin
            gap++;
        end
        prev_req = step_req;
    end

    task automatic pulse(input logic u, input logic d, input logic l, input logic r);
        BtnU_p = u; BtnD_p = d; BtnL_p = l; BtnR_p = r;
        @(negedge Clk);
        BtnU_p = 1'b0; BtnD_p = 1'b0; BtnL_p = 1'b0; BtnR_p = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (step_req) break;
        end
        chk("step_req_seen", 32'(step_req), 32'd1);
    endtask

    task automatic handshake(input logic f, input logic c);
        wait_req();
        @(negedge Clk);
        step_done = 1'b1; food_eaten = f; collide = c;
        @(negedge Clk);
        step_done = 1'b0; food_eaten = 1'b0; collide = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        repeat (2) @(negedge Clk);
        chk("rst_q_Ini", 32'(q_Ini), 32'd1);
        chk("rst_init_clr", 32'(init_clr), 32'd1);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_run_lose", 32'({q_Run, q_Lose}), 32'd0);
        chk("rst_step", 32'({step_req, step_dir}), 32'd0);
        chk("rst_other_ini", 32'({ini_nr, ini_s2, clr_nr, clr_s2}), 32'hF);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rel_q_Run", 32'(q_Run), 32'd1);
        chk("rel_q_Ini", 32'({q_Ini, init_clr}), 32'd0);
        chk("rel_other_run", 32'({run_nr, run_s2}), 32'd3);

        // Idle step, then button captures in RUN_WAIT
        push(2'b00, 2'b00, 2'b00);
        handshake(1'b0, 1'b0);
        chk("req_drop", 32'(step_req), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        push(2'b10, 2'b10, 2'b10);
        handshake(1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        push(2'b10, 2'b10, 2'b10);

        // BtnD during the step in flight (reverse of U: dropped on the no-reverse unit)
        wait_req();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("dir_in_flight", 32'(step_dir), 32'd2);
        step_done = 1'b1;
        @(negedge Clk);
        step_done = 1'b0;
        chk("dir_held_after_done", 32'(step_dir), 32'd2);
        push(2'b11, 2'b10, 2'b11);
        handshake(1'b0, 1'b0);

        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        push(2'b00, 2'b00, 2'b00);
        handshake(1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);

        // Food steps: 8-bit score counts, 2-bit score saturates at 3
        for (int k = 0; k < 5; k++) begin
            push(2'b01, 2'b00, 2'b01);
            handshake(1'b1, 1'b0);
            if (k == 2) begin
                chk("score_3", 32'(score), 32'd3);
                chk("score_s2_3", 32'(score_s2), 32'd3);
            end
        end
        chk("score_5", 32'(score), 32'd5);
        chk("score_nr_5", 32'(score_nr), 32'd5);
        chk("score_s2_sat", 32'(score_s2), 32'd3);

        // Collision with food: lose, score unchanged
        push(2'b01, 2'b00, 2'b01);
        handshake(1'b1, 1'b1);
        chk("q_Lose", 32'({q_Lose, lose_nr, lose_s2}), 32'd7);
        chk("lose_q_Run", 32'(q_Run), 32'd0);
        chk("lose_score", 32'(score), 32'd5);
        chk("lose_score_s2", 32'(score_s2), 32'd3);
        pulse(1'b1, 1'b1, 1'b1, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (step_req || req_nr || req_s2 || !q_Lose) hits++;
        end
        chk("lose_no_req", 32'(hits), 32'd0);
        chk("lose_score_frozen", 32'(score), 32'd5);

        // Reset from LOSE acts before the next edge
        #2 Reset = 1'b1;
        #1;
        chk("rst_lose_ini", 32'({q_Ini, init_clr, q_Lose}), 32'b110);
        chk("rst_lose_score", 32'(score), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_lose_run", 32'({q_Run, q_Ini}), 32'b10);

        // Reset in the middle of a step
        push(2'b00, 2'b00, 2'b00);
        wait_req();
        #2 Reset = 1'b1;
        #1;
        chk("rst_step_req", 32'({step_req, req_nr, req_s2}), 32'd0);
        chk("rst_step_ini", 32'({q_Ini, init_clr, q_Run}), 32'b110);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_step_run", 32'({q_Run, q_Ini}), 32'b10);
        push(2'b00, 2'b00, 2'b00);
        handshake(1'b0, 1'b0);
        chk("score_after_rst", 32'(score), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
